manchester_unescape: RTL and testbench
======================================

# manchester_unescape

Receive-side counterpart of the Manchester link escaper: accepts the escaped AXI-Stream byte stream recovered from the line and restores the original payload. Escape pairs collapse to one byte (E5 F5 → D5, E5 E5 → E5). Malformed sequences are forwarded with a per-beat error flag, so frame boundaries (tlast) are never lost. Sits between the deframer/byte aligner and the payload consumer.

## Interface
- DATA_WIDTH, 8, stream byte width
- ESCAPED_SYMBOL, 8'hD5, reserved line symbol that never appears raw in payload
- ESCAPE_SYMBOL, 8'hE5, escape prefix
- REPLACE_SYMBOL, 8'hF5, follower that encodes ESCAPED_SYMBOL
- ERR_CNT_WIDTH, 16, error counter width
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- s_axis_tdata  in  DATA_WIDTH  escaped input byte
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input end of frame
- m_axis_tdata  out  DATA_WIDTH  unescaped byte
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output end of frame
- m_axis_tuser  out  1  beat carries a decode error
- err_pulse  out  1  one-cycle strobe per decode error
- err_count  out  ERR_CNT_WIDTH  saturating decode error count

## Operation
- FSM states: NORMAL and ESC_SEEN. Reset state is NORMAL.
- Accept condition: s_axis_tvalid && s_axis_tready, with s_axis_tready = aresetn && (!m_axis_tvalid || m_axis_tready).
- Beats accepted in NORMAL:
  - ESCAPE_SYMBOL with tlast=0: consumed, no output, go to ESC_SEEN.
  - ESCAPE_SYMBOL with tlast=1 (dangling escape): output E5, tlast=1, tuser=1, error; stay NORMAL.
  - ESCAPED_SYMBOL (raw D5 in payload): output D5, tlast passed through, tuser=1, error.
  - Any other byte: output unchanged, tlast passed through, tuser=0.
- Beats accepted in ESC_SEEN (every case returns to NORMAL):
  - REPLACE_SYMBOL: output ESCAPED_SYMBOL, tuser=0.
  - ESCAPE_SYMBOL: output ESCAPE_SYMBOL, tuser=0.
  - Any other byte: output that byte, tuser=1, error.
  - The output tlast is always the second byte's tlast.
- Error effects:
  - err_pulse is high for exactly the cycle in which the error beat first presents m_axis_tvalid.
  - err_count increments by 1 per error and saturates at all-ones. It clears only on reset.
- The escaper's output never produces the error paths; they exist only for line corruption.

## Timing
- Reset values: m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, err_pulse=0, err_count=0, state NORMAL.
- s_axis_tready is 0 while aresetn=0 and 1 in the first cycle after reset release.
- Latency: one cycle from accepting the completing input beat to m_axis_tvalid=1.
- Throughput:
  - One output beat per cycle for unescaped data while m_axis_tready=1.
  - An escape pair takes two accept cycles and yields one output beat.
  - No bubble is inserted beyond the consumed prefix.
- Backpressure:
  - While m_axis_tvalid && !m_axis_tready, m_axis_tdata, m_axis_tlast and m_axis_tuser hold stable and s_axis_tready=0.
  - Same-cycle output handshake and new input accept are allowed: the register reloads with no gap.
- Prefix acceptance: an E5 prefix is only accepted under the normal ready rule, even though it produces no output.
- ESC_SEEN persists across idle cycles (s_axis_tvalid=0) indefinitely.
- Reset mid-frame: the pending output beat is dropped, ESC_SEEN is cleared, and the counter resets. No partial beat survives.

## Structure
- A shared package/include holds ESCAPED_SYMBOL, ESCAPE_SYMBOL and REPLACE_SYMBOL defaults. Escaper and unescaper both reference it so the two ends cannot diverge.
- The FSM state encoding is local.
- No sub-module: the FSM, output register and counter are inline.

## Test plan
- Input 01 E5 F5 02 E5 E5 03(tlast), m_axis_tready=1 → output 01 D5 02 E5 03(tlast), tuser all 0, err_count=0.
- Input E5 F5 with m_axis_tready held 0 for 5 cycles after the first output valid → D5 held stable, s_axis_tready=0 throughout, exactly one D5 delivered.
- Input 10 D5 11(tlast) → D5 output with tuser=1, err_pulse once, err_count=1, tlast on 11.
- Input 20 E5(tlast) → output 20, then E5 with tlast=1 and tuser=1, err_count=1, state NORMAL; the next frame 30(tlast) decodes cleanly.
- Input E5 7A → output 7A with tuser=1. Then E5, idle 10 cycles, F5 → output D5 with tuser=0.
- Assert aresetn=0 in ESC_SEEN with an output pending → all outputs 0. After release, input F5 → output F5 with tuser=0 (no stale escape).

Source files
------------

// File: rtl/manchester_unescape_pkg.sv
// Shared line-coding symbols for the Manchester link escaper/unescaper pair.
// Both ends take their defaults from here so the code tables cannot diverge.
package manchester_unescape_pkg;

    localparam int unsigned DATA_WIDTH_DEF     = 8;
    localparam int unsigned ERR_CNT_WIDTH_DEF  = 16;

    // Reserved line symbol; never appears raw in a well-formed payload.
    localparam logic [7:0]  ESCAPED_SYMBOL_DEF = 8'hD5;
    // Prefix that introduces a two-byte escape pair.
    localparam logic [7:0]  ESCAPE_SYMBOL_DEF  = 8'hE5;
    // Follower that encodes the reserved symbol inside a pair.
    localparam logic [7:0]  REPLACE_SYMBOL_DEF = 8'hF5;

endpackage : manchester_unescape_pkg

// File: rtl/manchester_unescape.sv
// Receive-side unescaper: collapses escape pairs back to payload bytes and
// forwards malformed sequences with a per-beat error flag (m_axis_tuser), so
// frame boundaries are always preserved. One output register stage.
module manchester_unescape
    import manchester_unescape_pkg::*;
#(
    parameter int unsigned              DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0]    ESCAPED_SYMBOL = DATA_WIDTH'(ESCAPED_SYMBOL_DEF),
    parameter logic [DATA_WIDTH-1:0]    ESCAPE_SYMBOL  = DATA_WIDTH'(ESCAPE_SYMBOL_DEF),
    parameter logic [DATA_WIDTH-1:0]    REPLACE_SYMBOL = DATA_WIDTH'(REPLACE_SYMBOL_DEF),
    parameter int unsigned              ERR_CNT_WIDTH  = ERR_CNT_WIDTH_DEF
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    output logic                        err_pulse,
    output logic [ERR_CNT_WIDTH-1:0]    err_count
);

    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_ESC_SEEN = 1'b1
    } state_e;

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = {ERR_CNT_WIDTH{1'b1}};

    state_e                     state_q,     state_d;
    logic [DATA_WIDTH-1:0]      tdata_q,     tdata_d;
    logic                       tvalid_q,    tvalid_d;
    logic                       tlast_q,     tlast_d;
    logic                       tuser_q,     tuser_d;
    logic                       err_pulse_q, err_pulse_d;
    logic [ERR_CNT_WIDTH-1:0]   err_count_q, err_count_d;

    logic                       ready_s;
    logic                       accept_s;
    logic                       load_s;
    logic                       bad_s;
    logic [DATA_WIDTH-1:0]      out_byte_s;

    // The output register may take a new beat when empty or draining this cycle.
    assign ready_s  = aresetn && (!tvalid_q || m_axis_tready);
    assign accept_s = s_axis_tvalid && ready_s;

    // Decode the accepted beat: decide whether it produces output, what byte, and whether it is malformed.
    always_comb begin
        state_d    = state_q;
        load_s     = 1'b0;
        bad_s      = 1'b0;
        out_byte_s = s_axis_tdata;
        if (accept_s) begin
            case (state_q)
                ST_NORMAL: begin
                    if (s_axis_tdata == ESCAPE_SYMBOL) begin
                        if (s_axis_tlast) begin
                            // Prefix with nothing left in the frame to pair with.
                            load_s = 1'b1;
                            bad_s  = 1'b1;
                        end else begin
                            // Prefix is swallowed; the follower completes the pair.
                            state_d = ST_ESC_SEEN;
                        end
                    end else if (s_axis_tdata == ESCAPED_SYMBOL) begin
                        load_s = 1'b1;
                        bad_s  = 1'b1;
                    end else begin
                        load_s = 1'b1;
                    end
                end
                ST_ESC_SEEN: begin
                    state_d = ST_NORMAL;
                    load_s  = 1'b1;
                    if (s_axis_tdata == REPLACE_SYMBOL) begin
                        out_byte_s = ESCAPED_SYMBOL;
                    end else if (s_axis_tdata == ESCAPE_SYMBOL) begin
                        out_byte_s = ESCAPE_SYMBOL;
                    end else begin
                        bad_s = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Next-state for the output register, error strobe and saturating error counter.
    always_comb begin
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        if (load_s) begin
            tdata_d     = out_byte_s;
            tvalid_d    = 1'b1;
            tlast_d     = s_axis_tlast;
            tuser_d     = bad_s;
            err_pulse_d = bad_s;
            if (bad_s && (err_count_q != ERR_CNT_MAX)) begin
                err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
            end else begin
                err_count_d = err_count_q;
            end
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_NORMAL;
            tdata_q     <= {DATA_WIDTH{1'b0}};
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= {ERR_CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign s_axis_tready = ready_s;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign err_pulse     = err_pulse_q;
    assign err_count     = err_count_q;

endmodule : manchester_unescape

// File: tb/tb_manchester_unescape.sv
// Self-checking bench for manchester_unescape: directed scenarios plus
// randomized streams compared against a pair-scanning reference model.
module tb_manchester_unescape;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       user;
    } beat_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic        err_pulse;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;
    int pulse_cnt = 0;
    int run_cycles = 0;
    beat_t in_q[$];
    beat_t exp_q[$];
    beat_t out_q[$];

    manchester_unescape dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .err_pulse     (err_pulse),
        .err_count     (err_count)
    );

    always #5 aclk = ~aclk;

    // Reference: scan the input as singles and (E5, follower) pairs.
    function automatic void build_expected();
        int i = 0;
        beat_t b, n;
        exp_q.delete();
        while (i < in_q.size()) begin
            b = in_q[i];
            if (b.d == 8'hE5 && !b.last) begin
                if (i + 1 < in_q.size()) begin
                    n = in_q[i+1];
                    if (n.d == 8'hF5)      exp_q.push_back({8'hD5, n.last, 1'b0});
                    else if (n.d == 8'hE5) exp_q.push_back({8'hE5, n.last, 1'b0});
                    else                   exp_q.push_back({n.d, n.last, 1'b1});
                end
                i += 2;
            end else begin
                exp_q.push_back({b.d, b.last, (b.d == 8'hE5) || (b.d == 8'hD5)});
                i += 1;
            end
        end
    endfunction

    function automatic int count_user();
        int n = 0;
        foreach (exp_q[k]) if (exp_q[k].user) n++;
        return n;
    endfunction

    // Drive in_q with random valid/ready; collect delivered beats in out_q.
    task automatic run_stream(input int pv, input int pr, input int n_exp, input int budget);
        int idx = 0;
        int cyc = 0;
        logic in_fire, out_fire;
        out_q.delete();
        pulse_cnt = 0;
        while ((idx < in_q.size() || out_q.size() < n_exp) && cyc < budget) begin
            if (idx < in_q.size() && $urandom_range(99) < pv) begin
                s_tvalid = 1'b1; s_tdata = in_q[idx].d; s_tlast = in_q[idx].last;
            end else begin
                s_tvalid = 1'b0; s_tdata = 8'($urandom); s_tlast = 1'($urandom);
            end
            m_tready = ($urandom_range(99) < pr);
            @(negedge aclk);
            in_fire  = s_tvalid && s_tready;
            out_fire = m_tvalid && m_tready;
            if (out_fire) out_q.push_back({m_tdata, m_tlast, m_tuser});
            if (err_pulse) pulse_cnt++;
            @(posedge aclk); #1;
            if (in_fire) idx++;
            cyc++;
        end
        run_cycles = cyc;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            if (m_tvalid && m_tready) out_q.push_back({m_tdata, m_tlast, m_tuser});
            if (err_pulse) pulse_cnt++;
            @(posedge aclk); #1;
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        exp_err = 0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; s_tvalid = 1'b1; s_tdata = 8'h11; s_tlast = 1'b0; m_tready = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({m_tdata, m_tvalid, m_tlast, m_tuser, err_pulse, err_count, s_tready} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h v=%b l=%b u=%b p=%b cnt=%0d rdy=%b required all 0",
                     m_tdata, m_tvalid, m_tlast, m_tuser, err_pulse, err_count, s_tready);
        end
        @(posedge aclk); #1;
        aresetn = 1'b1; s_tvalid = 1'b0;
        exp_err = 0;
        @(negedge aclk);
        checks++;
        if (s_tready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b required 1", s_tready);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_clean();
        in_q = '{ {8'h01,1'b0,1'b0}, {8'hE5,1'b0,1'b0}, {8'hF5,1'b0,1'b0}, {8'h02,1'b0,1'b0},
                  {8'hE5,1'b0,1'b0}, {8'hE5,1'b0,1'b0}, {8'h03,1'b1,1'b0} };
        build_expected();
        run_stream(100, 100, exp_q.size(), 100);
        checks++;
        if (out_q.size() != 5) begin
            errors++; $display("FAIL clean_count: got %0d required 5", out_q.size());
        end
        foreach (exp_q[k]) begin
            checks++;
            if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL clean_beat %0d: got %h required %h", k,
                                   (k < out_q.size()) ? out_q[k] : 10'h0, exp_q[k]);
            end
        end
        checks++;
        if (run_cycles != 8) begin
            errors++; $display("FAIL clean_throughput: got %0d cycles required 8", run_cycles);
        end
        checks++;
        if (err_count !== 16'd0) begin
            errors++; $display("FAIL clean_err_count: got %0d required 0", err_count);
        end
    endtask

    task automatic test_backpressure();
        logic fire;
        int   n = 0;
        m_tready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            s_tvalid = 1'b1; s_tdata = (b == 0) ? 8'hE5 : 8'hF5; s_tlast = (b == 1);
            fire = 1'b0;
            for (int t = 0; t < 20 && !fire; t++) begin
                @(negedge aclk);
                fire = s_tvalid && s_tready;
                @(posedge aclk); #1;
            end
            checks++;
            if (!fire) begin
                errors++; $display("FAIL bp_accept %0d: got not accepted required accepted", b);
            end
        end
        s_tvalid = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge aclk);
            checks++;
            if ({m_tvalid, m_tdata, m_tlast, m_tuser, s_tready} !== {1'b1, 8'hD5, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold %0d: got v=%b d=%h l=%b u=%b rdy=%b required v=1 d=d5 l=1 u=0 rdy=0",
                         t, m_tvalid, m_tdata, m_tlast, m_tuser, s_tready);
            end
            @(posedge aclk); #1;
        end
        m_tready = 1'b1;
        repeat (5) begin
            @(negedge aclk);
            if (m_tvalid && m_tready) n++;
            @(posedge aclk); #1;
        end
        checks++;
        if (n != 1) begin
            errors++; $display("FAIL bp_deliveries: got %0d required 1", n);
        end
    endtask

    task automatic test_raw_d5();
        in_q = '{ {8'h10,1'b0,1'b0}, {8'hD5,1'b0,1'b0}, {8'h11,1'b1,1'b0} };
        build_expected();
        exp_err += count_user();
        run_stream(100, 100, exp_q.size(), 100);
        checks++;
        if (out_q.size() != 3 || out_q[1] !== {8'hD5,1'b0,1'b1} || out_q[2] !== {8'h11,1'b1,1'b0}
            || out_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL raw_d5_beats: got %p required %p", out_q, exp_q);
        end
        checks++;
        if (pulse_cnt != 1) begin
            errors++; $display("FAIL raw_d5_pulse: got %0d required 1", pulse_cnt);
        end
        checks++;
        if (err_count !== 16'(exp_err)) begin
            errors++; $display("FAIL raw_d5_err_count: got %0d required %0d", err_count, exp_err);
        end
    endtask

    task automatic test_dangling();
        in_q = '{ {8'h20,1'b0,1'b0}, {8'hE5,1'b1,1'b0}, {8'h30,1'b1,1'b0} };
        build_expected();
        exp_err += count_user();
        run_stream(100, 100, exp_q.size(), 100);
        checks++;
        if (out_q.size() != 3 || out_q[0] !== {8'h20,1'b0,1'b0} || out_q[1] !== {8'hE5,1'b1,1'b1}
            || out_q[2] !== {8'h30,1'b1,1'b0}) begin
            errors++; $display("FAIL dangling_beats: got %p required %p", out_q, exp_q);
        end
        checks++;
        if (pulse_cnt != 1 || err_count !== 16'(exp_err)) begin
            errors++; $display("FAIL dangling_err: got pulses=%0d cnt=%0d required 1 and %0d",
                               pulse_cnt, err_count, exp_err);
        end
    endtask

    task automatic test_bad_escape_idle();
        in_q = '{ {8'hE5,1'b0,1'b0}, {8'h7A,1'b0,1'b0} };
        exp_err += 1;
        run_stream(100, 100, 1, 100);
        checks++;
        if (out_q.size() != 1 || out_q[0] !== {8'h7A,1'b0,1'b1}) begin
            errors++; $display("FAIL bad_escape_beat: got %p required 7a user=1", out_q);
        end
        in_q = '{ {8'hE5,1'b0,1'b0} };
        run_stream(100, 100, 0, 100);
        checks++;
        if (out_q.size() != 0) begin
            errors++; $display("FAIL prefix_no_output: got %0d beats required 0", out_q.size());
        end
        repeat (10) @(posedge aclk);
        #1;
        in_q = '{ {8'hF5,1'b1,1'b0} };
        run_stream(100, 100, 1, 100);
        checks++;
        if (out_q.size() != 1 || out_q[0] !== {8'hD5,1'b1,1'b0}) begin
            errors++; $display("FAIL idle_escape_beat: got %p required d5 last=1 user=0", out_q);
        end
        checks++;
        if (err_count !== 16'(exp_err)) begin
            errors++; $display("FAIL bad_escape_err_count: got %0d required %0d", err_count, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 8'h41; s_tlast = 1'b0;
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b1) begin
            errors++; $display("FAIL mid_pending: got v=%b required 1", m_tvalid);
        end
        aresetn = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk);
        checks++;
        if ({m_tdata, m_tvalid, m_tlast, m_tuser, err_pulse, err_count} !== 28'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got d=%h v=%b l=%b u=%b p=%b cnt=%0d required all 0",
                     m_tdata, m_tvalid, m_tlast, m_tuser, err_pulse, err_count);
        end
        @(posedge aclk); #1;
        aresetn = 1'b1; exp_err = 0; m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 8'hE5; s_tlast = 1'b0;
        @(posedge aclk); #1;
        s_tvalid = 1'b0; aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        in_q = '{ {8'hF5,1'b1,1'b0} };
        run_stream(100, 100, 1, 100);
        checks++;
        if (out_q.size() != 1 || out_q[0] !== {8'hF5,1'b1,1'b0}) begin
            errors++; $display("FAIL mid_no_stale_escape: got %p required f5 last=1 user=0", out_q);
        end
    endtask

    task automatic test_random();
        int r;
        logic [7:0] d;
        for (int it = 0; it < 4; it++) begin
            in_q.delete();
            for (int k = 0; k < 60; k++) begin
                r = $urandom_range(9);
                d = (r < 3) ? 8'hE5 : (r < 5) ? 8'hF5 : (r < 6) ? 8'hD5 : 8'($urandom);
                in_q.push_back({d, ($urandom_range(7) == 0) || (k == 59), 1'b0});
            end
            build_expected();
            exp_err += count_user();
            run_stream(70, 60, exp_q.size(), 3000);
            checks++;
            if (out_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rand_count it%0d: got %0d required %0d", it, out_q.size(), exp_q.size());
            end
            foreach (exp_q[k]) begin
                checks++;
                if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
                    errors++; $display("FAIL rand_beat it%0d/%0d: got %h required %h", it, k,
                                       (k < out_q.size()) ? out_q[k] : 10'h0, exp_q[k]);
                end
            end
            checks++;
            if (pulse_cnt != count_user() || err_count !== 16'(exp_err)) begin
                errors++; $display("FAIL rand_err it%0d: got pulses=%0d cnt=%0d required %0d and %0d",
                                   it, pulse_cnt, err_count, count_user(), exp_err);
            end
        end
    endtask

    initial begin
        aresetn = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; m_tready = 1'b1;
        @(posedge aclk); #1;
        test_reset();
        test_clean();
        test_backpressure();
        do_reset();
        test_raw_d5();
        test_dangling();
        do_reset();
        test_bad_escape_idle();
        test_reset_mid();
        do_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_manchester_unescape
